// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU response checker: opcodes, flag-vector
// layout and the default counter width.
package alu4_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } alu_op_e;

  // Bit positions inside the packed flag vector {nf, zf, cf, ovf, Cout}.
  localparam int unsigned FlagNf   = 4;
  localparam int unsigned FlagZf   = 3;
  localparam int unsigned FlagCf   = 2;
  localparam int unsigned FlagOvf  = 1;
  localparam int unsigned FlagCout = 0;
  localparam int unsigned FlagW    = 5;

  localparam int unsigned CntWDefault = 16;

endpackage

// File: rtl/alu4_ref.sv
// Combinational golden model of the 4-bit ALU: expected result and flags for a
// given opcode and operand pair.
module alu4_ref
  import alu4_pkg::*;
(
  input  logic [2:0] alusel,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y_exp,
  output logic       nf_exp,
  output logic       zf_exp,
  output logic       cf_exp,
  output logic       ovf_exp,
  output logic       cout_exp
);

  logic [4:0] add_sum;
  logic [4:0] sub_sum;

  // SUB is a + ~b + 1, so its carry out is 1 when no borrow occurred.
  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + 5'd1;

  always_comb begin
    y_exp   = 4'h0;
    cf_exp  = 1'b0;
    ovf_exp = 1'b0;
    unique case (alu_op_e'(alusel))
      OpAdd: begin
        y_exp   = add_sum[3:0];
        cf_exp  = add_sum[4];
        ovf_exp = (a[3] == b[3]) && (add_sum[3] != a[3]);
      end
      OpSub: begin
        y_exp   = sub_sum[3:0];
        cf_exp  = sub_sum[4];
        ovf_exp = (a[3] != b[3]) && (sub_sum[3] != a[3]);
      end
      OpAnd: y_exp = a & b;
      OpOr:  y_exp = a | b;
      OpXor: y_exp = a ^ b;
      OpNot: y_exp = ~a;
      OpShl: begin
        y_exp  = {a[2:0], 1'b0};
        cf_exp = a[3];
      end
      OpShr: begin
        y_exp  = {1'b0, a[3:1]};
        cf_exp = a[0];
      end
      default: y_exp = 4'h0;
    endcase
  end

  assign nf_exp   = y_exp[3];
  assign zf_exp   = (y_exp == 4'h0);
  assign cout_exp = cf_exp;

endmodule

// File: rtl/alu4_resp_checker.sv
// Checks sampled ALU responses against alu4_ref, reporting per-sample pass/fail
// one cycle later and keeping saturating counters plus a first-failure record.
module alu4_resp_checker
  import alu4_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             chk_valid,
  input  logic [2:0]       alusel,
  input  logic [3:0]       aluin_a,
  input  logic [3:0]       aluin_b,
  input  logic [3:0]       y,
  input  logic             nf,
  input  logic             zf,
  input  logic             cf,
  input  logic             ovf,
  input  logic             Cout,
  output logic             res_valid,
  output logic             res_pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [2:0]       fail_alusel,
  output logic [3:0]       fail_a,
  output logic [3:0]       fail_b,
  output logic [3:0]       fail_y_exp,
  output logic [3:0]       fail_y_got,
  output logic [4:0]       fail_flags_exp,
  output logic [4:0]       fail_flags_got
);

  logic [3:0]       y_exp;
  logic             nf_exp, zf_exp, cf_exp, ovf_exp, cout_exp;
  logic [FlagW-1:0] flags_exp, flags_got;
  logic             sample_pass;

  alu4_ref u_ref (
    .alusel   (alusel),
    .a        (aluin_a),
    .b        (aluin_b),
    .y_exp    (y_exp),
    .nf_exp   (nf_exp),
    .zf_exp   (zf_exp),
    .cf_exp   (cf_exp),
    .ovf_exp  (ovf_exp),
    .cout_exp (cout_exp)
  );

  always_comb begin
    flags_exp           = '0;
    flags_got           = '0;
    flags_exp[FlagNf]   = nf_exp;
    flags_exp[FlagZf]   = zf_exp;
    flags_exp[FlagCf]   = cf_exp;
    flags_exp[FlagOvf]  = ovf_exp;
    flags_exp[FlagCout] = cout_exp;
    flags_got[FlagNf]   = nf;
    flags_got[FlagZf]   = zf;
    flags_got[FlagCf]   = cf;
    flags_got[FlagOvf]  = ovf;
    flags_got[FlagCout] = Cout;
  end

  assign sample_pass = (y == y_exp) && (flags_got == flags_exp);

  // Pass/fail, counters and capture are all resolved at the sample edge so the
  // counters already reflect the sample in the cycle its res_valid is high.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      res_valid        <= 1'b0;
      res_pass         <= 1'b0;
      mismatch         <= 1'b0;
      chk_count        <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      fail_alusel      <= '0;
      fail_a           <= '0;
      fail_b           <= '0;
      fail_y_exp       <= '0;
      fail_y_got       <= '0;
      fail_flags_exp   <= '0;
      fail_flags_got   <= '0;
    end else begin
      res_valid <= chk_valid;
      res_pass  <= chk_valid && sample_pass;
      if (chk_valid) begin
        if (chk_count != '1) chk_count <= chk_count + CNT_W'(1);
        if (!sample_pass) begin
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
          mismatch <= 1'b1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            fail_alusel      <= alusel;
            fail_a           <= aluin_a;
            fail_b           <= aluin_b;
            fail_y_exp       <= y_exp;
            fail_y_got       <= y;
            fail_flags_exp   <= flags_exp;
            fail_flags_got   <= flags_got;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu4_resp_checker.sv
// Directed bench for alu4_resp_checker: hand-computed vectors, saturation,
// clr/rst priority and an exhaustive back-to-back sweep against a bench ALU.
module tb_alu4_resp_checker;

  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst, clr, chk_valid;
  logic [2:0]       alusel;
  logic [3:0]       aluin_a, aluin_b, y;
  logic             nf, zf, cf, ovf, Cout;
  logic             res_valid, res_pass, mismatch, first_fail_valid;
  logic [CNT_W-1:0] chk_count, err_count;
  logic [2:0]       fail_alusel;
  logic [3:0]       fail_a, fail_b, fail_y_exp, fail_y_got;
  logic [4:0]       fail_flags_exp, fail_flags_got;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu4_resp_checker #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .clr              (clr),
    .chk_valid        (chk_valid),
    .alusel           (alusel),
    .aluin_a          (aluin_a),
    .aluin_b          (aluin_b),
    .y                (y),
    .nf               (nf),
    .zf               (zf),
    .cf               (cf),
    .ovf              (ovf),
    .Cout             (Cout),
    .res_valid        (res_valid),
    .res_pass         (res_pass),
    .mismatch         (mismatch),
    .chk_count        (chk_count),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .fail_alusel      (fail_alusel),
    .fail_a           (fail_a),
    .fail_b           (fail_b),
    .fail_y_exp       (fail_y_exp),
    .fail_y_got       (fail_y_got),
    .fail_flags_exp   (fail_flags_exp),
    .fail_flags_got   (fail_flags_got)
  );

  // Bench ALU built from integer arithmetic; returns {y, nf, zf, cf, ovf, Cout}.
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int ua, ub, sa, sb, r, sr;
    logic [3:0] ry;
    logic rc, rv;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    rc = 1'b0;
    rv = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; sr = sa + sb; rc = (r > 15); rv = (sr > 7) || (sr < -8); end
      3'd1: begin r = ua - ub; sr = sa - sb; rc = (ua >= ub); rv = (sr > 7) || (sr < -8); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 15 - ua;
      3'd6: begin r = ua * 2; rc = (ua >= 8); end
      default: begin r = ua / 2; rc = (ua % 2) == 1; end
    endcase
    ry = r[3:0];
    return {ry, ry[3], ry == 4'h0, rc, rv, rc};
  endfunction

  task automatic set_vec(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] yy, input logic [4:0] f);
    alusel  = op;
    aluin_a = a;
    aluin_b = b;
    y       = yy;
    {nf, zf, cf, ovf, Cout} = f;
  endtask

  // One chk_valid cycle; returns #1 after the sampling edge.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] yy, input logic [4:0] f);
    set_vec(op, a, b, yy, f);
    chk_valid = 1'b1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b0;
    set_vec(3'd2, 4'hF, 4'h0, 4'h1, 5'b00000);
    chk_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_pass !== 1'b0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b pass=%b mismatch=%b, want 0 0 0",
               res_valid, res_pass, mismatch);
    end
    checks++;
    if (chk_count !== '0 || err_count !== '0 || first_fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: got chk=%0d err=%0d ffv=%b, want 0 0 0",
               chk_count, err_count, first_fail_valid);
    end
    checks++;
    if ({fail_alusel, fail_a, fail_b, fail_y_exp, fail_y_got, fail_flags_exp,
         fail_flags_got} !== '0) begin
      errors++;
      $display("FAIL reset_capture: got alusel=%h a=%h b=%h yexp=%h ygot=%h fexp=%b fgot=%b, want 0",
               fail_alusel, fail_a, fail_b, fail_y_exp, fail_y_got, fail_flags_exp, fail_flags_got);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_pass();
    do_clr();
    send(3'd0, 4'h4, 4'h3, 4'h7, 5'b00000);
    checks++;
    if (res_valid !== 1'b1 || res_pass !== 1'b1) begin
      errors++;
      $display("FAIL add_4_3_result: got valid=%b pass=%b, want 1 1", res_valid, res_pass);
    end
    checks++;
    if (chk_count !== 12'd1 || err_count !== 12'd0) begin
      errors++;
      $display("FAIL add_4_3_counts: got chk=%0d err=%0d, want 1 0", chk_count, err_count);
    end
    idle_cycle();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_valid: got res_valid=%b, want 0", res_valid);
    end
  endtask

  task automatic test_add_overflow();
    do_clr();
    send(3'd0, 4'h8, 4'h8, 4'h0, 5'b01111);
    checks++;
    if (res_valid !== 1'b1 || res_pass !== 1'b1 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL add_8_8_pass: got valid=%b pass=%b mismatch=%b, want 1 1 0",
               res_valid, res_pass, mismatch);
    end
    send(3'd0, 4'h8, 4'h8, 4'h0, 5'b01101);
    checks++;
    if (res_valid !== 1'b1 || res_pass !== 1'b0 || mismatch !== 1'b1) begin
      errors++;
      $display("FAIL add_8_8_ovf_fail: got valid=%b pass=%b mismatch=%b, want 1 0 1",
               res_valid, res_pass, mismatch);
    end
    checks++;
    if (fail_flags_exp !== 5'b01111 || fail_flags_got !== 5'b01101 ||
        first_fail_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_8_8_flags_capture: got exp=%b got=%b ffv=%b, want 01111 01101 1",
               fail_flags_exp, fail_flags_got, first_fail_valid);
    end
    checks++;
    if (chk_count !== 12'd2 || err_count !== 12'd1) begin
      errors++;
      $display("FAIL add_8_8_counts: got chk=%0d err=%0d, want 2 1", chk_count, err_count);
    end
  endtask

  task automatic test_first_capture();
    do_clr();
    send(3'd1, 4'h1, 4'h3, 4'hD, 5'b10000);
    checks++;
    if (res_pass !== 1'b0 || fail_y_exp !== 4'hE || fail_y_got !== 4'hD) begin
      errors++;
      $display("FAIL sub_1_3_capture: got pass=%b yexp=%h ygot=%h, want 0 e d",
               res_pass, fail_y_exp, fail_y_got);
    end
    send(3'd2, 4'hF, 4'h0, 4'h1, 5'b00000);
    checks++;
    if (res_valid !== 1'b1 || res_pass !== 1'b0 || err_count !== 12'd2) begin
      errors++;
      $display("FAIL and_second_fail: got valid=%b pass=%b err=%0d, want 1 0 2",
               res_valid, res_pass, err_count);
    end
    checks++;
    if (fail_alusel !== 3'd1 || fail_a !== 4'h1 || fail_b !== 4'h3 || fail_y_exp !== 4'hE ||
        fail_y_got !== 4'hD || fail_flags_exp !== 5'b10000 || fail_flags_got !== 5'b10000) begin
      errors++;
      $display("FAIL capture_held: got op=%h a=%h b=%h yexp=%h ygot=%h fexp=%b fgot=%b, want 1 1 3 e d 10000 10000",
               fail_alusel, fail_a, fail_b, fail_y_exp, fail_y_got, fail_flags_exp, fail_flags_got);
    end
  endtask

  task automatic test_saturation();
    do_clr();
    set_vec(3'd2, 4'hF, 4'h0, 4'h1, 5'b00000);
    chk_valid = 1'b1;
    for (int i = 0; i < (1 << CNT_W) - 2; i++) begin
      @(posedge clk);
    end
    #1;
    chk_valid = 1'b0;
    checks++;
    if (chk_count !== CntMax - 12'd1 || err_count !== CntMax - 12'd1) begin
      errors++;
      $display("FAIL sat_preload: got chk=%0d err=%0d, want %0d", chk_count, err_count,
               CntMax - 12'd1);
    end
    send(3'd2, 4'hF, 4'h0, 4'h1, 5'b00000);
    checks++;
    if (chk_count !== CntMax || err_count !== CntMax) begin
      errors++;
      $display("FAIL sat_reach: got chk=%0d err=%0d, want %0d", chk_count, err_count, CntMax);
    end
    send(3'd2, 4'hF, 4'h0, 4'h1, 5'b00000);
    send(3'd2, 4'hF, 4'h0, 4'h1, 5'b00000);
    checks++;
    if (chk_count !== CntMax || err_count !== CntMax || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: got chk=%0d err=%0d valid=%b, want %0d %0d 1",
               chk_count, err_count, res_valid, CntMax, CntMax);
    end
  endtask

  task automatic test_clr_priority();
    do_clr();
    set_vec(3'd2, 4'hF, 4'h0, 4'h1, 5'b00000);
    chk_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    chk_valid = 1'b0;
    clr = 1'b0;
    idle_cycle();
    checks++;
    if (res_valid !== 1'b0 || chk_count !== '0 || err_count !== '0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL clr_drop: got valid=%b chk=%0d err=%0d mismatch=%b, want 0 0 0 0",
               res_valid, chk_count, err_count, mismatch);
    end
  endtask

  task automatic test_rst_cancel();
    send(3'd2, 4'hF, 4'h0, 4'h1, 5'b00000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_pass !== 1'b0 || mismatch !== 1'b0 ||
        first_fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_cancel_flags: got valid=%b pass=%b mismatch=%b ffv=%b, want 0",
               res_valid, res_pass, mismatch, first_fail_valid);
    end
    checks++;
    if (chk_count !== '0 || err_count !== '0 || fail_y_got !== 4'h0 || fail_flags_exp !== 5'h0) begin
      errors++;
      $display("FAIL rst_cancel_state: got chk=%0d err=%0d ygot=%h fexp=%b, want 0",
               chk_count, err_count, fail_y_got, fail_flags_exp);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int passes = 0;
    logic [8:0] r;
    do_clr();
    chk_valid = 1'b1;
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 256; ab++) begin
        r = ref_alu(3'(op), 4'(ab >> 4), 4'(ab));
        set_vec(3'(op), 4'(ab >> 4), 4'(ab), r[8:5], r[4:0]);
        @(posedge clk); #1;
        if (res_valid === 1'b1) pulses++;
        if (res_valid === 1'b1 && res_pass === 1'b1) passes++;
      end
    end
    chk_valid = 1'b0;
    checks++;
    if (pulses !== 2048 || passes !== 2048) begin
      errors++;
      $display("FAIL sweep_pulses: got pulses=%0d passes=%0d, want 2048 2048", pulses, passes);
    end
    checks++;
    if (chk_count !== 12'd2048 || err_count !== 12'd0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL sweep_counts: got chk=%0d err=%0d mismatch=%b, want 2048 0 0",
               chk_count, err_count, mismatch);
    end
    idle_cycle();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_tail_idle: got res_valid=%b, want 0", res_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    chk_valid = 1'b0;
    set_vec(3'd0, 4'h0, 4'h0, 4'h0, 5'b00000);
    test_reset();
    test_add_pass();
    test_add_overflow();
    test_first_capture();
    test_saturation();
    test_clr_priority();
    test_rst_cancel();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu4_resp_checker.md
ALU4_RESP_CHECKER -- requirements
Module: alu4_resp_checker

Interface
REQ-001 Parameter CNT_W, default 16, width of the check and error counters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clr  input  1  synchronous clear of counters, sticky flag and capture registers.
REQ-005 chk_valid  input  1  this cycle's sample of the ALU ports is to be checked.
REQ-006 alusel  input  3  ALU opcode applied.
REQ-007 aluin_a, aluin_b  input  4 each  ALU operands applied.
REQ-008 y  input  4  ALU result observed.
REQ-009 nf, zf, cf, ovf, Cout  input  1 each  ALU flags observed.
REQ-010 res_valid  output  1  one-cycle pulse: a check result is presented.
REQ-011 res_pass  output  1  result and all five flags matched; meaningful only while res_valid is high.
REQ-012 mismatch  output  1  sticky: at least one failed check since reset/clr.
REQ-013 chk_count, err_count  output  CNT_W each  samples checked / samples failed.
REQ-014 first_fail_valid  output  1  capture registers hold the first failure.
REQ-015 fail_alusel 3, fail_a 4, fail_b 4, fail_y_exp 4, fail_y_got 4, fail_flags_exp 5, fail_flags_got 5  outputs  first-failure record; flag order {nf,zf,cf,ovf,Cout}.

Function
REQ-016 Expected model: 000 ADD a+b; 001 SUB a+~b+1; 010 AND; 011 OR; 100 XOR; 101 NOT a; 110 SHL a by 1; 111 SHR a by 1 (logical).
REQ-017 Expected nf = y_exp[3]; zf = (y_exp == 0).
REQ-018 Expected cf: ADD/SUB carry out of bit 3 (SUB: 1 = no borrow); SHL a[3]; SHR a[0]; 0 for logical ops.
REQ-019 Expected ovf: ADD a3==b3 and y3!=a3; SUB a3!=b3 and y3!=a3; 0 otherwise. Expected Cout equals expected cf.
REQ-020 The sample is registered on the chk_valid cycle; res_valid/res_pass assert on the following cycle (latency 1); back-to-back valids give back-to-back results.
REQ-021 chk_count increments in the res_valid cycle; err_count increments when res_valid and not res_pass; both saturate at all-ones and do not wrap.
REQ-022 On the first failure the fail_* registers load and first_fail_valid sets; later failures do not overwrite them.
REQ-023 mismatch sets with the first failure and holds until rst or clr.
REQ-024 clr has priority over chk_valid: a sample presented with clr is dropped, and any pending result is cancelled (no res_valid the next cycle).
REQ-025 res_valid is 0 in every cycle not directly following an accepted sample.

Reset
REQ-026 With rst high, on the clock edge all outputs and internal registers go to 0: res_valid, res_pass, mismatch, first_fail_valid, counters, all fail_* fields.
REQ-027 rst asserted mid-stream cancels any in-flight result; rst has priority over clr and chk_valid.

Structure
REQ-028 Package alu4_pkg holds the opcode constants (ADD..SHR), the flag-vector ordering, and the CNT_W default.
REQ-029 Expected-value computation lives in one combinational sub-module alu4_ref (inputs alusel, a, b; outputs y_exp and five expected flags); the checker holds registers, counters and capture logic only.

Verification
REQ-030 ADD 4+3, y=7, flags 00000 -> res_valid next cycle, res_pass=1, chk_count=1, err_count=0.
REQ-031 ADD 8+8, y=0, nf0 zf1 cf1 ovf1 Cout1 -> pass; same vector with ovf=0 -> fail, mismatch=1, fail_flags_exp=01111, fail_flags_got=01101.
REQ-032 SUB 1-3, y=E expected; inject y=D -> fail, fail_y_exp=E, fail_y_got=D; a second failing vector (AND F,0 with y=1) leaves captures unchanged, err_count=2.
REQ-033 Preload counters near saturation (2^CNT_W-2 checks), 3 further failing vectors -> both counters hold at all-ones.
REQ-034 chk_valid with clr in same cycle -> no res_valid next cycle, counters 0; chk_valid then rst next cycle -> no res_valid, all outputs 0.
REQ-035 All 8 ops x 256 operand pairs fed back-to-back from a correct ALU -> 2048 consecutive res_valid pulses, all pass, chk_count=2048, mismatch=0.
